// File: rtl/pll_lock_supervisor.sv
// Supervises the video PLL's reset/lock handshake: pulses the PLL reset, qualifies lock
// for a stable window before releasing system reset, retries on timeout, latches a fault.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned PW = (RST_PULSE_CYCLES   > 1) ? $clog2(RST_PULSE_CYCLES)   : 1;
  localparam int unsigned TW = (LOCK_TIMEOUT       > 1) ? $clog2(LOCK_TIMEOUT)       : 1;
  localparam int unsigned SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pulse_q, pulse_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            meta_q, locked_s_q;
  logic            pll_rst_q, sys_rst_n_q, ready_q, fault_q;
  logic            timeout;

  // pll_locked comes from another clock domain; nothing downstream sees it unsynchronized.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      meta_q     <= pll_locked;
      locked_s_q <= meta_q;
    end
  end

  assign timeout = ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) && (timer_q == TIMEOUT_LAST);

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    timer_d = timer_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    // The attempt deadline outranks everything else, including a same-cycle STABLE->RUN.
    if (timeout) begin
      retry_d = retry_q + 4'd1;
      pulse_d = '0;
      state_d = ((retry_q + 4'd1) == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (pulse_q == PULSE_LAST) begin
            state_d = S_WAIT_LOCK;
            pulse_d = '0;
            timer_d = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          timer_d = timer_q + 1'b1;
          if (locked_s_q) begin
            state_d = S_STABLE;
            stab_d  = '0;
          end
        end
        S_STABLE: begin
          timer_d = timer_q + 1'b1;
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
            stab_d  = '0;
          end else if (stab_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d = S_RESET_PLL;
            pulse_d = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        S_FAULT: ;
        default: state_d = S_RESET_PLL;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      pulse_q     <= '0;
      timer_q     <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      timer_q     <= timer_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule
